// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants, phase encoding and helpers for the sync generator.
// Defaults describe 640x480 @ 60 Hz from a 50 MHz clock (one pixel per 2 clocks).
package vga_timing_pkg;

    localparam int unsigned CntW   = 10;
    localparam int unsigned MaxTot = 1 << CntW;

    localparam int unsigned DefClkDiv = 2;
    localparam int unsigned DefHVis   = 640;
    localparam int unsigned DefHFp    = 16;
    localparam int unsigned DefHSync  = 96;
    localparam int unsigned DefHBp    = 48;
    localparam int unsigned DefVVis   = 480;
    localparam int unsigned DefVFp    = 10;
    localparam int unsigned DefVSync  = 2;
    localparam int unsigned DefVBp    = 33;

    localparam int unsigned DefHTot = DefHVis + DefHFp + DefHSync + DefHBp;
    localparam int unsigned DefVTot = DefVVis + DefVFp + DefVSync + DefVBp;

    typedef enum logic [1:0] {PH_VIS, PH_FP, PH_SYNC, PH_BP} phase_e;

    function automatic int unsigned axis_total(int unsigned vis, int unsigned fp,
                                               int unsigned sync, int unsigned bp);
        return vis + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle: coordinates, sync pins, visibility flag and strobes.
// The generator drives it through master; pixel/colour logic samples it through slave.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic [CntW-1:0] VGAx;
    logic [CntW-1:0] VGAy;
    logic            hsync;
    logic            vsync;
    logic            video_on;
    logic            pix_tick;
    logic            line_start;
    logic            frame_start;

    modport master (
        output VGAx, VGAy, hsync, vsync, video_on, pix_tick, line_start, frame_start
    );

    modport slave (
        input VGAx, VGAy, hsync, vsync, video_on, pix_tick, line_start, frame_start
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus visible/porch/sync/porch phase FSM.
// Next-state values are exported so the top can register outputs on the same edge.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned VIS  = DefHVis,
    parameter int unsigned FP   = DefHFp,
    parameter int unsigned SYNC = DefHSync,
    parameter int unsigned BP   = DefHBp
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en_i,
    output logic [CntW-1:0] next_count_o,
    output phase_e          next_phase_o,
    output logic            wrap_o
);

    localparam int unsigned     Tot       = axis_total(VIS, FP, SYNC, BP);
    localparam logic [CntW-1:0] Last      = CntW'(Tot - 1);
    localparam logic [CntW-1:0] FpStart   = CntW'(VIS);
    localparam logic [CntW-1:0] SyncStart = CntW'(VIS + FP);
    localparam logic [CntW-1:0] BpStart   = CntW'(VIS + FP + SYNC);

    logic [CntW-1:0] count_q, count_d;
    phase_e          phase_q, phase_d;

    assign wrap_o = en_i && (count_q == Last);

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = wrap_o ? '0 : count_q + 1'b1;
        end
    end

    // Phase transitions are keyed on the incoming count so phase_q stays aligned with count_q.
    always_comb begin
        phase_d = phase_q;
        if (en_i) begin
            case (phase_q)
                PH_VIS:  if (count_d == FpStart)   phase_d = PH_FP;
                PH_FP:   if (count_d == SyncStart) phase_d = PH_SYNC;
                PH_SYNC: if (count_d == BpStart)   phase_d = PH_BP;
                PH_BP:   if (wrap_o)               phase_d = PH_VIS;
                default:                           phase_d = PH_BP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= Last;
            phase_q <= PH_BP;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign next_count_o = count_d;
    assign next_phase_o = phase_d;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, horizontal and vertical axis counters,
// and registered coordinate/sync/visibility outputs that all change on the advancing edge.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DefClkDiv,
    parameter int unsigned H_VIS    = DefHVis,
    parameter int unsigned H_FP     = DefHFp,
    parameter int unsigned H_SYNC   = DefHSync,
    parameter int unsigned H_BP     = DefHBp,
    parameter int unsigned V_VIS    = DefVVis,
    parameter int unsigned V_FP     = DefVFp,
    parameter int unsigned V_SYNC   = DefVSync,
    parameter int unsigned V_BP     = DefVBp,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic           clk,
    input  logic           rstn,
    vga_sync_gen_if.master vga_o
);

    localparam int unsigned H_TOT = axis_total(H_VIS, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOT = axis_total(V_VIS, V_FP, V_SYNC, V_BP);
    localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    if (CLK_DIV == 0 || H_VIS == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_VIS == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        H_TOT > MaxTot || V_TOT > MaxTot) begin : gen_bad_params
        $error("vga_sync_gen: illegal timing parameters");
    end

    logic [DivW-1:0] div_q, div_d;
    logic            pix_tick;

    assign pix_tick = (div_q == DivLast);
    assign div_d    = pix_tick ? '0 : div_q + DivW'(1);

    logic [CntW-1:0] h_next, v_next;
    phase_e          h_nphase, v_nphase;
    logic            h_wrap, v_wrap;

    vga_axis_counter #(
        .VIS  (H_VIS),
        .FP   (H_FP),
        .SYNC (H_SYNC),
        .BP   (H_BP)
    ) u_h_axis (
        .clk          (clk),
        .rstn         (rstn),
        .en_i         (pix_tick),
        .next_count_o (h_next),
        .next_phase_o (h_nphase),
        .wrap_o       (h_wrap)
    );

    vga_axis_counter #(
        .VIS  (V_VIS),
        .FP   (V_FP),
        .SYNC (V_SYNC),
        .BP   (V_BP)
    ) u_v_axis (
        .clk          (clk),
        .rstn         (rstn),
        .en_i         (h_wrap),
        .next_count_o (v_next),
        .next_phase_o (v_nphase),
        .wrap_o       (v_wrap)
    );

    logic            vis_d;
    logic [CntW-1:0] x_q, y_q;
    logic            hsync_q, vsync_q, video_on_q, line_start_q, frame_start_q;

    assign vis_d = (h_nphase == PH_VIS) && (v_nphase == PH_VIS);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            video_on_q    <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            // Wrap flags already include pix_tick, so the strobes last exactly one clk.
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
            if (pix_tick) begin
                video_on_q <= vis_d;
                x_q        <= vis_d ? h_next : '0;
                y_q        <= vis_d ? v_next : '0;
                hsync_q    <= (h_nphase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
                vsync_q    <= (v_nphase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    assign vga_o.VGAx        = x_q;
    assign vga_o.VGAy        = y_q;
    assign vga_o.hsync       = hsync_q;
    assign vga_o.vsync       = vsync_q;
    assign vga_o.video_on    = video_on_q;
    assign vga_o.pix_tick    = pix_tick;
    assign vga_o.line_start  = line_start_q;
    assign vga_o.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: three generator configurations share clk/rstn; a raster model predicts
// every cycle's outputs from the clock count since reset release, a monitor compares.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hsync;
        logic       vsync;
        logic       video_on;
        logic       pix_tick;
        logic       line_start;
        logic       frame_start;
    } out_t;

    typedef struct packed {
        int unsigned div;
        int unsigned hv, hf, hs, hb;
        int unsigned vv, vf, vs, vb;
        bit          pol;
    } cfg_t;

    localparam cfg_t CfgA = '{div: 2, hv: 640, hf: 16, hs: 96, hb: 48,
                              vv: 480, vf: 10, vs: 2, vb: 33, pol: 1'b0};
    localparam cfg_t CfgB = '{div: 1, hv: 4, hf: 1, hs: 2, hb: 1,
                              vv: 3, vf: 1, vs: 1, vb: 1, pol: 1'b1};
    localparam cfg_t CfgC = '{div: 3, hv: 6, hf: 2, hs: 3, hb: 2,
                              vv: 4, vf: 2, vs: 2, vb: 1, pol: 1'b0};

    logic clk;
    logic rstn;

    vga_sync_gen_if if_a ();
    vga_sync_gen_if if_b ();
    vga_sync_gen_if if_c ();

    vga_sync_gen u_dut_a (.clk(clk), .rstn(rstn), .vga_o(if_a));

    vga_sync_gen #(
        .CLK_DIV (CfgB.div), .H_VIS (CfgB.hv), .H_FP (CfgB.hf), .H_SYNC (CfgB.hs),
        .H_BP (CfgB.hb), .V_VIS (CfgB.vv), .V_FP (CfgB.vf), .V_SYNC (CfgB.vs),
        .V_BP (CfgB.vb), .SYNC_POL (CfgB.pol)
    ) u_dut_b (.clk(clk), .rstn(rstn), .vga_o(if_b));

    vga_sync_gen #(
        .CLK_DIV (CfgC.div), .H_VIS (CfgC.hv), .H_FP (CfgC.hf), .H_SYNC (CfgC.hs),
        .H_BP (CfgC.hb), .V_VIS (CfgC.vv), .V_FP (CfgC.vf), .V_SYNC (CfgC.vs),
        .V_BP (CfgC.vb), .SYNC_POL (CfgC.pol)
    ) u_dut_c (.clk(clk), .rstn(rstn), .vga_o(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    out_t got_a, got_b, got_c;
    assign got_a = {if_a.VGAx, if_a.VGAy, if_a.hsync, if_a.vsync, if_a.video_on,
                    if_a.pix_tick, if_a.line_start, if_a.frame_start};
    assign got_b = {if_b.VGAx, if_b.VGAy, if_b.hsync, if_b.vsync, if_b.video_on,
                    if_b.pix_tick, if_b.line_start, if_b.frame_start};
    assign got_c = {if_c.VGAx, if_c.VGAy, if_c.hsync, if_c.vsync, if_c.video_on,
                    if_c.pix_tick, if_c.line_start, if_c.frame_start};

    out_t q_a[$];
    out_t q_b[$];
    out_t q_c[$];

    int checks = 0;
    int errors = 0;
    longint unsigned k = 0;

    // k = clock edges seen with rstn high; pixel index p = k/div - 1 walks the raster.
    function automatic out_t model(input cfg_t c, input longint unsigned kk);
        out_t o;
        longint unsigned ht, vt, adv, p, h, v;
        ht = longint'(c.hv) + c.hf + c.hs + c.hb;
        vt = longint'(c.vv) + c.vf + c.vs + c.vb;
        o = '0;
        o.hsync = ~c.pol;
        o.vsync = ~c.pol;
        o.pix_tick = ((kk % c.div) == longint'(c.div) - 1);
        adv = kk / c.div;
        if (adv != 0) begin
            p = adv - 1;
            h = p % ht;
            v = (p / ht) % vt;
            o.video_on = (h < c.hv) && (v < c.vv);
            if (o.video_on) begin
                o.x = 10'(h);
                o.y = 10'(v);
            end
            o.hsync = (h >= c.hv + c.hf && h < c.hv + c.hf + c.hs) ? c.pol : ~c.pol;
            o.vsync = (v >= c.vv + c.vf && v < c.vv + c.vf + c.vs) ? c.pol : ~c.pol;
            o.line_start = ((kk % c.div) == 0) && (h == 0);
            o.frame_start = o.line_start && (v == 0);
        end
        return o;
    endfunction

    task automatic step(input bit rst_level);
        @(posedge clk);
        if (rstn) k++;
        #2;
        rstn = rst_level;
        if (!rst_level) k = 0;
        q_a.push_back(model(CfgA, k));
        q_b.push_back(model(CfgB, k));
        q_c.push_back(model(CfgC, k));
    endtask

    task automatic cmp(input string name, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t k=%0d got x=%0d y=%0d hs=%b vs=%b von=%b pt=%b ls=%b fs=%b %s",
                     name, $time, k, got.x, got.y, got.hsync, got.vsync, got.video_on,
                     got.pix_tick, got.line_start, got.frame_start,
                     $sformatf("required x=%0d y=%0d hs=%b vs=%b von=%b pt=%b ls=%b fs=%b",
                               exp.x, exp.y, exp.hsync, exp.vsync, exp.video_on,
                               exp.pix_tick, exp.line_start, exp.frame_start));
        end
    endtask

    always @(negedge clk) begin
        if (q_a.size() > 0) cmp("default", got_a, q_a.pop_front());
        if (q_b.size() > 0) cmp("div1_pol1", got_b, q_b.pop_front());
        if (q_c.size() > 0) cmp("div3_small", got_c, q_c.pop_front());
    end

    initial begin
        rstn = 1'b1;
        #1 rstn = 1'b0;
        repeat (5) step(1'b0);
        // Long first run: default config covers more than two full lines.
        repeat (4000) step(1'b1);
        // Random mid-frame resets, each asserted between clock edges.
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(1500, 50)) step(1'b1);
            repeat ($urandom_range(4, 1)) step(1'b0);
        end
        repeat (3400) step(1'b1);
        @(negedge clk);
        #1;
        checks++;
        if (q_a.size() + q_b.size() + q_c.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending entries required 0",
                     q_a.size() + q_b.size() + q_c.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
